vga_sram_fetcher: RTL and testbench
===================================

VGA_SRAM_FETCHER -- requirements
Module: vga_sram_fetcher

Interface
REQ-001 Parameter FB_BASE, 19'h00000, first framebuffer byte address in SRAM.
REQ-002 Parameter FB_BYTES, 307200, bytes per frame (640x480, 8 bpp); FB_BASE+FB_BYTES SHALL be <= 2^19.
REQ-003 Parameter FIFO_DEPTH, 16, pixel FIFO entries (power of two, >= 4).
REQ-004 Parameter LOW_WATER, 8, fill level at or below which a fetch burst starts (< FIFO_DEPTH).
REQ-005 CLK_I  in  1  single system clock; all logic on rising edge.
REQ-006 RST_N_I  in  1  reset, asynchronous assert, active-low.
REQ-007 ENABLE_I  in  1  fetching permitted when high.
REQ-008 FRAME_START_I  in  1  one-cycle pulse: restart frame at FB_BASE.
REQ-009 PIX_RD_I  in  1  pixel consumer pops one byte this cycle.
REQ-010 PIX_DAT_O  out  8  head-of-FIFO byte.
REQ-011 PIX_VALID_O  out  1  FIFO not empty.
REQ-012 UNDERRUN_O  out  1  sticky: pop attempted while empty.
REQ-013 VGA_REQ_O  out  1  registered read request to SRAM controller port (has priority over Wishbone).
REQ-014 VGA_ADR_O  out  19  registered read address, valid with VGA_REQ_O.
REQ-015 SRAM_DAT_I  in  8  read data from SRAM controller DAT_O.

Function
REQ-016 Read pipeline: request high in cycle k -> SRAM_DAT_I sampled into FIFO at rising edge ending cycle k+2; fixed 2-cycle latency, one byte per cycle, back-to-back requests allowed.
REQ-017 In-flight tracking: 2-stage valid shift register; fill = FIFO count + in-flight count.
REQ-018 A request SHALL be issued only when fill < FIFO_DEPTH; FIFO SHALL never overflow.
REQ-019 States: IDLE, WAIT, BURST, DONE.
REQ-020 IDLE: no requests; FRAME_START_I with ENABLE_I -> WAIT, address := FB_BASE.
REQ-021 WAIT: no requests; fill <= LOW_WATER -> BURST.
REQ-022 BURST: VGA_REQ_O high each cycle, address +1 per issued request; leave to WAIT when next issue would make fill = FIFO_DEPTH (last request included).
REQ-023 Request for address FB_BASE+FB_BYTES-1 is last of frame -> DONE; no further requests, no address wrap.
REQ-024 DONE: FIFO drains normally; await FRAME_START_I.
REQ-025 ENABLE_I low: VGA_REQ_O low next cycle, state -> IDLE; in-flight data still written; FIFO contents kept.
REQ-026 FRAME_START_I in any state: FIFO flushed, in-flight valids cleared (returning data discarded), UNDERRUN_O cleared, address := FB_BASE, state -> WAIT (IDLE if ENABLE_I low); pops in same cycle ignored.
REQ-027 Simultaneous push and pop: count unchanged, both take effect.
REQ-028 Pop while empty: no pointer change, PIX_DAT_O holds last value, UNDERRUN_O set until FRAME_START_I or reset.
REQ-029 PIX_DAT_O is combinational FIFO head (first-word fall-through); valid when PIX_VALID_O high.

Reset
REQ-030 RST_N_I low: state IDLE, VGA_REQ_O 0, VGA_ADR_O FB_BASE, FIFO empty, PIX_VALID_O 0, PIX_DAT_O 0, UNDERRUN_O 0, in-flight cleared.
REQ-031 Reset mid-burst SHALL drop VGA_REQ_O asynchronously; data returning after release SHALL be discarded.

Structure
REQ-032 Shared package holds SRAM address width (19), data width (8), default frame geometry constants and state encoding.
REQ-033 FIFO SHALL be sub-module vga_byte_fifo (FWFT, count output, synchronous flush, async active-low reset).

Verification
REQ-034 Reset, ENABLE_I=1, FRAME_START_I pulse, no pops -> exactly 16 requests at addresses 0..15 consecutive, then VGA_REQ_O stays low, PIX_VALID_O high, count 16.
REQ-035 From full FIFO pop 8 bytes -> BURST resumes, exactly 8 requests at addresses 16..23; popped bytes equal SRAM model contents at 0..7 in order.
REQ-036 FB_BYTES=40, continuous pops -> last request address 39, state DONE, 40 bytes delivered in order, then PIX_VALID_O low.
REQ-037 FRAME_START_I one cycle after a request with 2 bytes in flight -> those bytes never enter FIFO; next request address 0; first popped byte = SRAM[0].
REQ-038 Pop on empty FIFO -> UNDERRUN_O 1 next cycle and held; FRAME_START_I -> UNDERRUN_O 0.
REQ-039 RST_N_I asserted mid-burst -> VGA_REQ_O 0 immediately, all outputs at reset values; after release no requests until FRAME_START_I.

Source files
------------

// File: rtl/vga_sram_fetcher_pkg.sv
// Shared widths, default frame geometry and fetch FSM encoding for the
// VGA framebuffer fetch path.
package vga_sram_fetcher_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 8;
  localparam int FB_WIDTH     = 640;
  localparam int FB_HEIGHT    = 480;
  localparam int FB_BYTES_DEF = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vga_byte_fifo.sv
// First-word fall-through byte FIFO with occupancy count and synchronous flush.
// Flush moves the write pointer back to the read pointer so the head byte is untouched.
module vga_byte_fifo
  import vga_sram_fetcher_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_pop;
  logic              do_push;

  // A pop on an empty FIFO is ignored; a push is refused only when full and not popping.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/vga_sram_fetcher.sv
// Fetches framebuffer bytes from SRAM over a fixed 2-cycle read port into a pixel
// FIFO, bursting whenever the committed fill drops to the low-water mark.
module vga_sram_fetcher
  import vga_sram_fetcher_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter int                FB_BYTES   = FB_BYTES_DEF,
  parameter int                FIFO_DEPTH = 16,
  parameter int                LOW_WATER  = 8,
  parameter int                CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic              ENABLE_I,
  input  logic              FRAME_START_I,
  input  logic              PIX_RD_I,
  output logic [DATA_W-1:0] PIX_DAT_O,
  output logic              PIX_VALID_O,
  output logic              UNDERRUN_O,
  output logic              VGA_REQ_O,
  output logic [ADDR_W-1:0] VGA_ADR_O,
  input  logic [DATA_W-1:0] SRAM_DAT_I,
  output logic [1:0]        DBG_STATE_O,
  output logic [CNT_W-1:0]  DBG_COUNT_O
);

  localparam int                FW       = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(int'(FB_BASE) + FB_BYTES - 1);

  fetch_state_e      state_q;
  logic              req_q;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] nxt_q;
  logic              v1_q;
  logic              v2_q;
  logic              underrun_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;
  logic [FW-1:0]     fill;
  logic              issue_ok;
  logic              fill_at_limit;

  // Fill counts every byte already committed: stored, on the bus, or in the read pipe.
  assign fill          = FW'(fifo_count) + FW'(req_q) + FW'(v1_q) + FW'(v2_q);
  assign issue_ok      = fill < FW'(FIFO_DEPTH);
  assign fill_at_limit = fill == FW'(FIFO_DEPTH - 1);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      adr_q      <= FB_BASE;
      nxt_q      <= FB_BASE;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      v1_q <= req_q && !FRAME_START_I;
      v2_q <= v1_q && !FRAME_START_I;
      if (FRAME_START_I) begin
        req_q      <= 1'b0;
        adr_q      <= FB_BASE;
        nxt_q      <= FB_BASE;
        underrun_q <= 1'b0;
        state_q    <= ENABLE_I ? ST_WAIT : ST_IDLE;
      end else begin
        if (PIX_RD_I && !fifo_valid) underrun_q <= 1'b1;
        if (!ENABLE_I) begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: req_q <= 1'b0;
            ST_WAIT: begin
              req_q <= 1'b0;
              if (fill <= FW'(LOW_WATER)) state_q <= ST_BURST;
            end
            ST_BURST: begin
              if (issue_ok) begin
                req_q <= 1'b1;
                adr_q <= nxt_q;
                nxt_q <= nxt_q + 1'b1;
                if (nxt_q == LAST_ADR)  state_q <= ST_DONE;
                else if (fill_at_limit) state_q <= ST_WAIT;
              end else begin
                req_q   <= 1'b0;
                state_q <= ST_WAIT;
              end
            end
            ST_DONE: req_q <= 1'b0;
            default: begin
              req_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  vga_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_n_i (RST_N_I),
    .flush_i (FRAME_START_I),
    .push_i  (v2_q && !FRAME_START_I),
    .din_i   (SRAM_DAT_I),
    .pop_i   (PIX_RD_I && !FRAME_START_I),
    .dout_o  (PIX_DAT_O),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign PIX_VALID_O = fifo_valid;
  assign UNDERRUN_O  = underrun_q;
  assign VGA_REQ_O   = req_q;
  assign VGA_ADR_O   = adr_q;
  assign DBG_STATE_O = state_q;
  assign DBG_COUNT_O = fifo_count;

endmodule

// File: tb/tb_vga_sram_fetcher.sv
// Bench for vga_sram_fetcher: 40-byte frame, randomized SRAM contents and pop gaps,
// checked against a frame-level model of addresses, delivered bytes and occupancy.
module tb_vga_sram_fetcher;
  import vga_sram_fetcher_pkg::*;

  localparam int DEPTH = 16;
  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        rst_n, enable, frame_start, pix_rd;
  logic [7:0]  pix_dat, sram_dat;
  logic        pix_valid, underrun, vga_req;
  logic [18:0] vga_adr;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_count;

  always #5 clk = ~clk;

  vga_sram_fetcher #(
    .FB_BASE (19'h00000), .FB_BYTES (FRAME), .FIFO_DEPTH (DEPTH), .LOW_WATER (8)
  ) dut (
    .CLK_I (clk), .RST_N_I (rst_n), .ENABLE_I (enable), .FRAME_START_I (frame_start),
    .PIX_RD_I (pix_rd), .PIX_DAT_O (pix_dat), .PIX_VALID_O (pix_valid),
    .UNDERRUN_O (underrun), .VGA_REQ_O (vga_req), .VGA_ADR_O (vga_adr),
    .SRAM_DAT_I (sram_dat), .DBG_STATE_O (dbg_state), .DBG_COUNT_O (dbg_count)
  );

  // SRAM model: data for the address on the bus in cycle k is presented in cycle k+2.
  logic [7:0]  sram_mem [64];
  logic [18:0] sram_a1 = '0, sram_a2 = '0;
  always @(posedge clk) begin
    sram_a1 <= vga_adr;
    sram_a2 <= sram_a1;
  end
  assign sram_dat = sram_mem[sram_a2[5:0]];

  int checks = 0, errors = 0;
  int exp_adr = 0, frame_reqs = 0, frame_pops = 0, phase_reqs = 0;
  logic [18:0] last_adr = '0;

  // Request monitor: sequential addresses, never past the frame, never over-committed.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vga_req === 1'b1) begin
      checks++;
      if (vga_adr !== 19'(exp_adr)) begin
        errors++; $display("FAIL req_adr: got %0d expected %0d", vga_adr, exp_adr);
      end
      checks++;
      if (int'(vga_adr) >= FRAME) begin
        errors++; $display("FAIL req_past_frame: got %0d expected < %0d", vga_adr, FRAME);
      end
      last_adr = vga_adr;
      exp_adr++; frame_reqs++; phase_reqs++;
      checks++;
      if (frame_reqs - frame_pops > DEPTH) begin
        errors++; $display("FAIL overcommit: got %0d expected <= %0d", frame_reqs - frame_pops, DEPTH);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_new_frame();
    exp_adr = 0; frame_reqs = 0; frame_pops = 0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    model_new_frame();
  endtask

  task automatic pop_one();
    pix_rd = 1'b1;
    checks++;
    if (pix_valid !== 1'b1 || pix_dat !== sram_mem[frame_pops % 64]) begin
      errors++; $display("FAIL pop_data[%0d]: got %h valid %b expected %h", frame_pops, pix_dat, pix_valid, sram_mem[frame_pops % 64]);
    end
    frame_pops++;
    tick(); pix_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
    repeat (3) tick();
    checks++; if (vga_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", vga_req); end
    checks++; if (vga_adr !== 19'h0) begin errors++; $display("FAIL rst_adr: got %h expected 0", vga_adr); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", pix_valid); end
    checks++; if (pix_dat !== 8'h00) begin errors++; $display("FAIL rst_dat: got %h expected 00", pix_dat); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
    rst_n = 1'b1; enable = 1'b1;
    repeat (3) tick();
    checks++; if (dbg_state !== ST_IDLE || vga_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_rst: got state %0d req %b expected 0/0", dbg_state, vga_req);
    end
  endtask

  task automatic test_fill();
    pulse_frame_start();
    repeat (40) tick();
    checks++; if (frame_reqs != 16) begin errors++; $display("FAIL fill_reqs: got %0d expected 16", frame_reqs); end
    checks++; if (last_adr !== 19'd15) begin errors++; $display("FAIL fill_last_adr: got %0d expected 15", last_adr); end
    checks++; if (vga_req !== 1'b0 || pix_valid !== 1'b1) begin
      errors++; $display("FAIL fill_idle: got req %b valid %b expected 0/1", vga_req, pix_valid);
    end
    checks++; if (dbg_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", dbg_count); end
  endtask

  task automatic test_low_water();
    phase_reqs = 0;
    repeat (8) pop_one();
    repeat (30) tick();
    checks++; if (phase_reqs != 8) begin errors++; $display("FAIL lw_reqs: got %0d expected 8", phase_reqs); end
    checks++; if (last_adr !== 19'd23) begin errors++; $display("FAIL lw_last_adr: got %0d expected 23", last_adr); end
    checks++; if (dbg_count !== 5'd16) begin errors++; $display("FAIL lw_count: got %0d expected 16", dbg_count); end
  endtask

  task automatic test_frame_drain();
    int cyc = 0;
    while (frame_pops < FRAME && cyc < 3000) begin
      if (pix_valid === 1'b1 && $urandom_range(0, 3) != 0) pop_one();
      else tick();
      cyc++;
    end
    checks++; if (frame_pops != FRAME) begin errors++; $display("FAIL drain_timeout: got %0d pops expected %0d", frame_pops, FRAME); end
    checks++; if (last_adr !== 19'(FRAME - 1)) begin errors++; $display("FAIL drain_last_adr: got %0d expected %0d", last_adr, FRAME - 1); end
    checks++; if (frame_reqs != FRAME) begin errors++; $display("FAIL drain_reqs: got %0d expected %0d", frame_reqs, FRAME); end
    checks++; if (dbg_state !== ST_DONE) begin errors++; $display("FAIL drain_state: got %0d expected %0d", dbg_state, ST_DONE); end
    repeat (4) tick();
    checks++; if (pix_valid !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got valid %b underrun %b expected 0/0", pix_valid, underrun);
    end
  endtask

  task automatic test_frame_restart();
    int seen = 0, cyc = 0;
    pulse_frame_start();
    while (seen < 2 && cyc < 50) begin
      tick();
      if (vga_req === 1'b1) seen++;
      cyc++;
    end
    checks++; if (seen != 2) begin errors++; $display("FAIL restart_wait: got %0d reqs expected 2", seen); end
    tick();
    pulse_frame_start();
    checks++; if (dbg_count !== 5'd0) begin errors++; $display("FAIL restart_flush: got %0d expected 0", dbg_count); end
    repeat (40) tick();
    checks++; if (frame_reqs != 16 || dbg_count !== 5'd16) begin
      errors++; $display("FAIL restart_refill: got reqs %0d count %0d expected 16/16", frame_reqs, dbg_count);
    end
    repeat (3) pop_one();
  endtask

  task automatic test_enable_drop();
    int cyc = 0;
    pulse_frame_start();
    while (vga_req !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    checks++; if (vga_req !== 1'b1) begin errors++; $display("FAIL en_wait: got req %b expected 1", vga_req); end
    enable = 1'b0;
    tick();
    checks++; if (vga_req !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL en_drop: got req %b state %0d expected 0/%0d", vga_req, dbg_state, ST_IDLE);
    end
    repeat (5) tick();
    checks++; if (dbg_count !== 5'(frame_reqs)) begin
      errors++; $display("FAIL en_inflight: got %0d expected %0d", dbg_count, frame_reqs);
    end
  endtask

  task automatic test_underrun();
    int cyc = 0;
    while (pix_valid === 1'b1 && cyc < 40) begin pop_one(); cyc++; end
    pix_rd = 1'b1; tick(); pix_rd = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
    repeat (3) tick();
    checks++; if (underrun !== 1'b1 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL underrun_hold: got %b valid %b expected 1/0", underrun, pix_valid);
    end
    pulse_frame_start();
    checks++; if (underrun !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL underrun_clear: got %b state %0d expected 0/%0d", underrun, dbg_state, ST_IDLE);
    end
    repeat (10) tick();
    checks++; if (frame_reqs != 0) begin errors++; $display("FAIL idle_no_req: got %0d expected 0", frame_reqs); end
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    enable = 1'b1;
    pulse_frame_start();
    while (vga_req !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vga_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b expected 0", vga_req); end
    checks++; if (vga_adr !== 19'h0 || dbg_state !== ST_IDLE || pix_valid !== 1'b0 || pix_dat !== 8'h00 || underrun !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs: got adr %h state %0d valid %b dat %h und %b expected 0/0/0/00/0",
                         vga_adr, dbg_state, pix_valid, pix_dat, underrun);
    end
    tick();
    #2 rst_n = 1'b1;
    model_new_frame();
    repeat (20) tick();
    checks++; if (frame_reqs != 0 || dbg_count !== 5'd0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL post_rst_quiet: got reqs %0d count %0d state %0d expected 0/0/%0d",
                         frame_reqs, dbg_count, dbg_state, ST_IDLE);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = 8'($urandom);
    test_reset();
    test_fill();
    test_low_water();
    test_frame_drain();
    test_frame_restart();
    test_enable_drop();
    test_underrun();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
